serdes_lane_align_ctrl: RTL and testbench

//  Sequences word alignment of N_LANES ISERDESE2 lanes (8:1 DDR) that share one training pattern.

---
 rtl/serdes_lane_align_ctrl_pkg.sv | 18 +
 rtl/serdes_lane_align_ctrl_lane_check.sv | 40 ++++
 rtl/serdes_lane_align_ctrl.sv | 155 +++++++++++++++
 tb/tb_serdes_lane_align_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_lane_align_ctrl_pkg.sv
// Shared types and defaults for the ISERDESE2 lane word-alignment controller.
package serdes_lane_align_ctrl_pkg;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [WORD_W-1:0] DEFAULT_TRAINING_PATTERN = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SLIP  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/serdes_lane_align_ctrl_lane_check.sv
// Selects one lane of the deserialised bus and registers its compare against the training pattern.
module serdes_lane_align_ctrl_lane_check
    import serdes_lane_align_ctrl_pkg::*;
#(
    parameter int unsigned         N_LANES = 4,
    parameter int unsigned         SEL_W   = 3,
    parameter logic [WORD_W-1:0]   PATTERN = DEFAULT_TRAINING_PATTERN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WORD_W*N_LANES-1:0]   data_in,
    input  logic [SEL_W-1:0]            sel,
    output logic                        match
);

    logic [WORD_W-1:0] word_c;
    logic              match_d;
    logic              match_q;

    always_comb begin
        word_c = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (sel == SEL_W'(i)) begin
                word_c = data_in[i*WORD_W +: WORD_W];
            end
        end
        match_d = (word_c == PATTERN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/serdes_lane_align_ctrl.sv
// Walks the lanes one at a time, bit-slipping each until the training pattern is seen
// MATCH_CNT times in a row, and reports per-lane lock, pass completion and failure.
module serdes_lane_align_ctrl
    import serdes_lane_align_ctrl_pkg::*;
#(
    parameter int unsigned       N_LANES          = 4,
    parameter logic [WORD_W-1:0] TRAINING_PATTERN = DEFAULT_TRAINING_PATTERN,
    parameter int unsigned       WAIT_TIME        = 5,
    parameter int unsigned       MATCH_CNT        = 4,
    parameter int unsigned       MAX_SLIPS        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WORD_W*N_LANES-1:0]   data_in,
    output logic [N_LANES-1:0]          BS,
    output logic [N_LANES-1:0]          aligned,
    output logic                        busy,
    output logic                        done,
    output logic                        fail
);

    localparam int unsigned LANE_W = $clog2(N_LANES) + 1;

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    slip_cnt_q, slip_cnt_d;
    logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
    logic [N_LANES-1:0]  bs_q, bs_d;
    logic [N_LANES-1:0]  aligned_q, aligned_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;
    logic [N_LANES-1:0]  lane_oh_c;
    logic                match;

    // Compare is steered by the next lane so its registered result lines up with lane_q.
    serdes_lane_align_ctrl_lane_check #(
        .N_LANES (N_LANES),
        .SEL_W   (LANE_W),
        .PATTERN (TRAINING_PATTERN)
    ) u_lane_check (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .sel     (lane_d),
        .match   (match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            wait_cnt_q  <= '0;
            slip_cnt_q  <= '0;
            match_cnt_q <= '0;
            bs_q        <= '0;
            aligned_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            wait_cnt_q  <= wait_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
            match_cnt_q <= match_cnt_d;
            bs_q        <= bs_d;
            aligned_q   <= aligned_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: begin
                if (match) begin
                    if (match_cnt_q + CNT_W'(1) == CNT_W'(MATCH_CNT)) state_d = ST_NEXT;
                end else begin
                    state_d = (slip_cnt_q == CNT_W'(MAX_SLIPS)) ? ST_NEXT : ST_SLIP;
                end
            end
            ST_SLIP:  state_d = ST_WAIT;
            ST_WAIT:  if (wait_cnt_q == CNT_W'(WAIT_TIME - 1)) state_d = ST_CHECK;
            ST_NEXT:  state_d = (lane_q == LANE_W'(N_LANES - 1)) ? ST_DONE : ST_CHECK;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lane_oh_c   = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (lane_q == LANE_W'(i)) lane_oh_c[i] = 1'b1;
        end
        lane_d      = lane_q;
        wait_cnt_d  = wait_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        match_cnt_d = match_cnt_q;
        aligned_d   = aligned_q;
        busy_d      = busy_q;
        fail_d      = fail_q;
        bs_d        = (state_d == ST_SLIP) ? lane_oh_c : '0;
        done_d      = (state_d == ST_DONE);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    aligned_d   = '0;
                    fail_d      = 1'b0;
                    lane_d      = '0;
                    busy_d      = 1'b1;
                    wait_cnt_d  = '0;
                    slip_cnt_d  = '0;
                    match_cnt_d = '0;
                end
            end
            ST_CHECK: begin
                if (match) begin
                    match_cnt_d = match_cnt_q + CNT_W'(1);
                    if (state_d == ST_NEXT) aligned_d = aligned_q | lane_oh_c;
                end else begin
                    match_cnt_d = '0;
                    if (state_d == ST_NEXT) fail_d = 1'b1;
                end
            end
            ST_SLIP: begin
                if (slip_cnt_q != CNT_W'(MAX_SLIPS)) slip_cnt_d = slip_cnt_q + CNT_W'(1);
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (state_d == ST_CHECK) match_cnt_d = '0;
            end
            ST_NEXT: begin
                slip_cnt_d  = '0;
                match_cnt_d = '0;
                if (state_d == ST_CHECK) lane_d = lane_q + LANE_W'(1);
            end
            ST_DONE: busy_d = 1'b0;
            default: ;
        endcase
    end

    assign BS      = bs_q;
    assign aligned = aligned_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign fail    = fail_q;

endmodule

// File: tb/tb_serdes_lane_align_ctrl.sv
// Bench for serdes_lane_align_ctrl: each lane is a rotating copy of the training word (one step
// per BS pulse), a stuck word, or a toggling word; pass outcomes come from a per-lane slip model.
module tb_serdes_lane_align_ctrl;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 5;
    localparam int unsigned M   = 4;
    localparam int unsigned MS  = 8;
    localparam logic [7:0]  PAT = 8'hF0;
    localparam int          BUDGET = 3000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [8*N-1:0] data_in;
    logic [N-1:0]   bs, aligned;
    logic           busy, done, fail;

    int      mode  [N];
    int      phase [N];
    int      pulses[N];
    int      last_pulse[N];
    bit      last_valid[N];
    bit      tog = 1'b0;
    bit      mon_en = 1'b0;
    int      done_cnt = 0;
    int      cyc = 0;
    int      n_assert = 0;
    int      n_fail = 0;
    logic [N-1:0] prev_bs = '0, prev_aligned = '0;
    logic    prev_busy = 1'b0;

    serdes_lane_align_ctrl #(
        .N_LANES          (N),
        .TRAINING_PATTERN (PAT),
        .WAIT_TIME        (W),
        .MATCH_CNT        (M),
        .MAX_SLIPS        (MS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .BS      (bs),
        .aligned (aligned),
        .busy    (busy),
        .done    (done),
        .fail    (fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] w, input int p);
        logic [15:0] t;
        t = {w, w} << p;
        return t[15:8];
    endfunction

    function automatic logic [7:0] lane_word(input int k);
        case (mode[k])
            1:       return 8'hAA;
            2:       return tog ? 8'hF0 : 8'h0F;
            default: return rotl(PAT, phase[k]);
        endcase
    endfunction

    // Lane environment plus continuous protocol checks on BS / aligned / done.
    always @(negedge clk) begin
        if (mon_en) begin
            check("bs_onehot", ($countones(bs) > 1) ? 32'd1 : 32'd0, 32'd0);
            check("bs_one_cycle", 32'(bs & prev_bs), 32'd0);
            if (prev_busy && busy) check("aligned_hold", 32'(prev_aligned & ~aligned), 32'd0);
            for (int k = 0; k < N; k++) begin
                if (bs[k]) begin
                    pulses[k]++;
                    if (last_valid[k])
                        check("bs_gap", (cyc - last_pulse[k] >= int'(W) + 1) ? 32'd1 : 32'd0, 32'd1);
                    last_pulse[k] = cyc;
                    last_valid[k] = 1'b1;
                    phase[k] = (phase[k] + 1) % 8;
                end
            end
            if (done === 1'b1) done_cnt++;
        end
        prev_bs      = bs;
        prev_aligned = aligned;
        prev_busy    = busy;
        tog          = ~tog;
        for (int k = 0; k < N; k++) data_in[8*k +: 8] = lane_word(k);
    end

    task automatic clear_book();
        for (int k = 0; k < N; k++) begin
            pulses[k]     = 0;
            last_valid[k] = 1'b0;
        end
        done_cnt = 0;
    endtask

    task automatic set_lanes(input int m0, p0, m1, p1, m2, p2, m3, p3);
        mode[0] = m0; phase[0] = p0; mode[1] = m1; phase[1] = p1;
        mode[2] = m2; phase[2] = p2; mode[3] = m3; phase[3] = p3;
        @(negedge clk);
    endtask

    // Expected outcome per lane: rotator lanes need (8-phase)%8 slips then lock; stuck or
    // toggling lanes burn all MAX_SLIPS and fail.
    task automatic run_pass(input string name, input bit extra_starts);
        int           exp_p[N];
        logic [N-1:0] exp_al;
        logic         exp_fail;
        int           lat, cnt;
        bit           lat_ok;
        exp_al = '0; exp_fail = 1'b0; lat = 1; lat_ok = 1'b1;
        for (int k = 0; k < N; k++) begin
            case (mode[k])
                0: begin
                    exp_p[k]  = (8 - phase[k]) % 8;
                    exp_al[k] = 1'b1;
                    lat += int'(M) + 1 + exp_p[k] * (int'(W) + 2);
                end
                1: begin
                    exp_p[k] = MS; exp_fail = 1'b1;
                    lat += int'(MS) * (int'(W) + 2) + 2;
                end
                default: begin
                    exp_p[k] = MS; exp_fail = 1'b1; lat_ok = 1'b0;
                end
            endcase
        end
        clear_book();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        check({name, "_busy_rise"}, 32'(busy), 32'd1);
        check({name, "_aligned_clr"}, 32'(aligned), 32'd0);
        check({name, "_fail_clr"}, 32'(fail), 32'd0);
        while (done !== 1'b1 && cnt < BUDGET) begin
            if (extra_starts) start = (cnt % 7 == 3);
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        check({name, "_done_seen"}, 32'(done), 32'd1);
        if (lat_ok) check({name, "_latency"}, 32'(cnt), 32'(lat));
        check({name, "_aligned"}, 32'(aligned), 32'(exp_al));
        check({name, "_fail"}, 32'(fail), 32'(exp_fail));
        for (int k = 0; k < N; k++) check({name, "_pulses"}, 32'(pulses[k]), 32'(exp_p[k]));
        repeat (4) @(negedge clk);
        check({name, "_done_once"}, 32'(done_cnt), 32'd1);
        check({name, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    // Start a pass, wait for the first slip on a lane, then reset a few cycles later.
    task automatic reset_mid(input string name, input int lane, input int delay);
        int cnt;
        clear_book();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (bs[lane] !== 1'b1 && cnt < BUDGET) begin
            @(negedge clk);
            cnt++;
        end
        check({name, "_slip_seen"}, 32'(bs[lane]), 32'd1);
        repeat (delay) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({name, "_bs"}, 32'(bs), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_aligned"}, 32'(aligned), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            mode[k] = 0; phase[k] = 0; pulses[k] = 0; last_pulse[k] = 0; last_valid[k] = 1'b0;
        end
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_bs", 32'(bs), 32'd0);
        check("rst_aligned", 32'(aligned), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("start_during_rst", 32'(busy), 32'd0);
        mon_en = 1'b1;

        set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
        run_pass("all_aligned", 1'b0);

        set_lanes(0, 0, 0, 0, 0, 5, 0, 0);
        run_pass("lane2_off3", 1'b0);

        set_lanes(0, 0, 1, 0, 0, 0, 0, 0);
        run_pass("lane1_stuck", 1'b0);
        repeat (10) @(negedge clk);
        check("fail_sticky", 32'(fail), 32'd1);

        set_lanes(0, 5, 0, 0, 0, 0, 0, 0);
        reset_mid("rst_wait_l0", 0, 2);
        run_pass("rerun_after_rst", 1'b0);

        set_lanes(0, 0, 0, 0, 0, 6, 0, 0);
        reset_mid("rst_slip_l2", 2, 0);
        run_pass("rerun_after_rst2", 1'b0);

        set_lanes(0, 3, 0, 0, 0, 0, 0, 7);
        run_pass("start_while_busy", 1'b1);

        set_lanes(0, 0, 0, 0, 0, 0, 2, 0);
        run_pass("lane3_toggle", 1'b0);

        for (int r = 0; r < 4; r++) begin
            set_lanes(0, $urandom_range(0, 7), 0, $urandom_range(0, 7),
                      0, $urandom_range(0, 7), 0, $urandom_range(0, 7));
            run_pass("rand_rot", 1'b0);
        end
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) begin
                mode[k]  = ($urandom_range(0, 3) == 0) ? 1 : 0;
                phase[k] = $urandom_range(0, 7);
            end
            @(negedge clk);
            run_pass("rand_mixed", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
